axi_lite_clint: RTL

//  Parametrised CLINT behind a 32-bit AXI4-Lite slave port: per-hart msip and 64-bit mtimecmp, one shared 64-bit mtime.

---
 rtl/axi_lite_clint.sv | 172 +++++++++++++++++
 1 files changed

// File: rtl/axi_lite_clint.sv
// axi_lite_clint: AXI4-Lite CLINT with per-hart msip/mtimecmp, one shared prescaled 64-bit mtime.
module axi_lite_clint #(
  parameter logic [31:0] BASE_ADDR = 32'h0200_0000,
  parameter int          NUM_HARTS = 1,
  parameter int          PRESCALE  = 1
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic [31:0]          s_axi_awaddr_i,
  input  logic                 s_axi_awvalid_i,
  output logic                 s_axi_awready_o,
  input  logic [31:0]          s_axi_wdata_i,
  input  logic [3:0]           s_axi_wstrb_i,
  input  logic                 s_axi_wvalid_i,
  output logic                 s_axi_wready_o,
  output logic [1:0]           s_axi_bresp_o,
  output logic                 s_axi_bvalid_o,
  input  logic                 s_axi_bready_i,
  input  logic [31:0]          s_axi_araddr_i,
  input  logic                 s_axi_arvalid_i,
  output logic                 s_axi_arready_o,
  output logic [31:0]          s_axi_rdata_o,
  output logic [1:0]           s_axi_rresp_o,
  output logic                 s_axi_rvalid_o,
  input  logic                 s_axi_rready_i,
  output logic [NUM_HARTS-1:0] msip_o,
  output logic [NUM_HARTS-1:0] mtip_o
);
  localparam int HW = NUM_HARTS > 1 ? $clog2(NUM_HARTS) : 1;
  localparam int CW = PRESCALE > 1 ? $clog2(PRESCALE) : 1;

  typedef enum logic [1:0] {K_NONE, K_MSIP, K_CMP, K_TIME} kind_e;
  typedef enum logic {R_IDLE, R_RESP} r_state_e;
  typedef enum logic [1:0] {W_IDLE, W_GOT_AW, W_GOT_W, W_RESP} w_state_e;

  function automatic kind_e decode(input logic [13:0] w);
    return 32'(w) < NUM_HARTS ? K_MSIP :
           (w[13:1] >= 13'h800 && 32'(w[13:1]) < 32'h800 + NUM_HARTS) ? K_CMP :
           w[13:1] == 13'h17ff ? K_TIME : K_NONE;
  endfunction

  function automatic logic [31:0] merge(input logic [31:0] o, input logic [31:0] d, input logic [3:0] s);
    logic [31:0] m;
    for (int i = 0; i < 4; i++) m[8*i +: 8] = s[i] ? d[8*i +: 8] : o[8*i +: 8];
    return m;
  endfunction

  r_state_e             r_q, r_d;
  w_state_e             w_q, w_d;
  logic [31:0]          awaddr_q, awaddr_d, wdata_q, wdata_d, rdata_q, rdata_d;
  logic [3:0]           wstrb_q, wstrb_d;
  logic [1:0]           rresp_q, rresp_d, bresp_q, bresp_d;
  logic [NUM_HARTS-1:0] msip_q, msip_d;
  logic [63:0]          cmp_q [NUM_HARTS];
  logic [63:0]          cmp_d [NUM_HARTS];
  logic [63:0]          mtime_q, mtime_d;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic [31:0]          ar_off, aw_a, aw_off, wd, rd_val, wr_old, wr_new;
  logic [3:0]           ws;
  kind_e                ar_k, aw_k;
  logic [HW-1:0]        ar_h, aw_h;
  logic                 ar_hs, aw_hs, w_hs, do_wr, tick;
  logic                 unused_addr;

  assign unused_addr = ^{ar_off[31:16], ar_off[1:0], aw_off[31:16], aw_off[1:0]};

  always_comb begin
    s_axi_arready_o = r_q == R_IDLE;
    s_axi_rvalid_o  = r_q == R_RESP;
    ar_hs           = s_axi_arvalid_i && s_axi_arready_o;
    r_d             = ar_hs ? R_RESP : s_axi_rvalid_o && s_axi_rready_i ? R_IDLE : r_q;
  end

  always_comb begin
    s_axi_awready_o = w_q == W_IDLE || w_q == W_GOT_W;
    s_axi_wready_o  = w_q == W_IDLE || w_q == W_GOT_AW;
    s_axi_bvalid_o  = w_q == W_RESP;
    aw_hs           = s_axi_awvalid_i && s_axi_awready_o;
    w_hs            = s_axi_wvalid_i && s_axi_wready_o;
    do_wr           = (aw_hs || w_q == W_GOT_AW) && (w_hs || w_q == W_GOT_W);
    w_d             = do_wr ? W_RESP : aw_hs ? W_GOT_AW : w_hs ? W_GOT_W :
                      s_axi_bvalid_o && s_axi_bready_i ? W_IDLE : w_q;
  end

  always_comb begin
    ar_off = s_axi_araddr_i - BASE_ADDR;
    ar_k   = decode(ar_off[15:2]);
    ar_h   = ar_k == K_MSIP ? ar_off[HW+1:2] : ar_off[HW+2:3];
    rd_val = ar_k == K_TIME ? (ar_off[2] ? mtime_q[63:32] : mtime_q[31:0]) : '0;
    for (int i = 0; i < NUM_HARTS; i++) begin
      if (ar_h == HW'(i) && ar_k == K_MSIP) rd_val = {31'b0, msip_q[i]};
      if (ar_h == HW'(i) && ar_k == K_CMP) rd_val = ar_off[2] ? cmp_q[i][63:32] : cmp_q[i][31:0];
    end
    rdata_d = ar_hs ? rd_val : rdata_q;
    rresp_d = ar_hs ? (ar_k == K_NONE ? 2'b10 : 2'b00) : rresp_q;
  end

  always_comb begin
    awaddr_d = aw_hs ? s_axi_awaddr_i : awaddr_q;
    wdata_d  = w_hs ? s_axi_wdata_i : wdata_q;
    wstrb_d  = w_hs ? s_axi_wstrb_i : wstrb_q;
    aw_a     = awaddr_d;
    wd       = wdata_d;
    ws       = wstrb_d;
    aw_off   = aw_a - BASE_ADDR;
    aw_k     = decode(aw_off[15:2]);
    aw_h     = aw_k == K_MSIP ? aw_off[HW+1:2] : aw_off[HW+2:3];
    wr_old   = aw_k == K_TIME ? (aw_off[2] ? mtime_q[63:32] : mtime_q[31:0]) : '0;
    for (int i = 0; i < NUM_HARTS; i++) begin
      if (aw_h == HW'(i) && aw_k == K_MSIP) wr_old = {31'b0, msip_q[i]};
      if (aw_h == HW'(i) && aw_k == K_CMP) wr_old = aw_off[2] ? cmp_q[i][63:32] : cmp_q[i][31:0];
    end
    wr_new   = merge(wr_old, wd, ws);
    bresp_d  = do_wr ? (aw_k == K_NONE ? 2'b10 : 2'b00) : bresp_q;
  end

  always_comb begin
    tick    = cnt_q == CW'(PRESCALE - 1);
    cnt_d   = tick ? '0 : cnt_q + CW'(1);
    mtime_d = tick ? mtime_q + 64'd1 : mtime_q;
    msip_d  = msip_q;
    cmp_d   = cmp_q;
    for (int i = 0; i < NUM_HARTS; i++) begin
      if (do_wr && aw_h == HW'(i) && aw_k == K_MSIP) msip_d[i] = wr_new[0];
      if (do_wr && aw_h == HW'(i) && aw_k == K_CMP)
        cmp_d[i] = aw_off[2] ? {wr_new, cmp_q[i][31:0]} : {cmp_q[i][63:32], wr_new};
    end
    if (do_wr && aw_k == K_TIME && |ws) begin
      mtime_d = aw_off[2] ? {wr_new, mtime_q[31:0]} : {mtime_q[63:32], wr_new};
      cnt_d   = '0;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_q      <= R_IDLE;
      w_q      <= W_IDLE;
      awaddr_q <= '0;
      wdata_q  <= '0;
      wstrb_q  <= '0;
      rdata_q  <= '0;
      rresp_q  <= '0;
      bresp_q  <= '0;
      msip_q   <= '0;
      mtime_q  <= '0;
      cnt_q    <= '0;
      for (int i = 0; i < NUM_HARTS; i++) cmp_q[i] <= '1;
    end else begin
      r_q      <= r_d;
      w_q      <= w_d;
      awaddr_q <= awaddr_d;
      wdata_q  <= wdata_d;
      wstrb_q  <= wstrb_d;
      rdata_q  <= rdata_d;
      rresp_q  <= rresp_d;
      bresp_q  <= bresp_d;
      msip_q   <= msip_d;
      mtime_q  <= mtime_d;
      cnt_q    <= cnt_d;
      cmp_q    <= cmp_d;
    end
  end

  assign s_axi_rdata_o = rdata_q;
  assign s_axi_rresp_o = rresp_q;
  assign s_axi_bresp_o = bresp_q;
  assign msip_o        = msip_q;

  for (genvar g = 0; g < NUM_HARTS; g++) begin : g_mtip
    assign mtip_o[g] = mtime_q >= cmp_q[g];
  end
endmodule
